ifetch: RTL
===========

# ifetch

Instruction fetch stage: owns the program counter, issues word-addressed reads to instruction memory, and buffers returned instructions in a small in-order FIFO. It feeds the decode stage with instruction word, PC and a valid flag. Decode backpressure is accepted through a stall input, and branch/jump redirects from later stages flush all in-flight work.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `DEPTH`, default 2: instruction FIFO entries; also the maximum in-flight plus buffered fetches (power of 2, ≥2).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: word address of the request (current PC).
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid. In order, ≥1 cycle after acceptance, no backpressure.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in 32: new PC when `redirect`=1.
- `id_stall` in 1: decode cannot accept this cycle.
- `if_valid` out 1: `if_inst`/`if_pc` hold a valid instruction.
- `if_inst` out 32: instruction word (decode fields: [27:22] rd, [21:16] rs, [15:10] rt).
- `if_pc` out 32: PC of `if_inst`, used by decode for PC-save.

## Operation
- State: `pc`, `outstanding` (accepted, not yet returned), `drop_cnt` (returns to discard), FIFO of {pc, inst}.
- Pop: `pop = if_valid & ~id_stall`.
- Issue: `imem_req = rst_n & ~redirect & (fifo_count + outstanding - pop < DEPTH)`.
- Acceptance (`imem_req & imem_ready`) pushes `pc` into the in-flight PC queue. `pc <= pc + 1` (word addressing, 32-bit wrap). `outstanding` increments.
- Return (`imem_rvalid`): `outstanding` decrements.
  - If `drop_cnt` ≠ 0: discard the data and decrement `drop_cnt`.
  - Otherwise: push {queued pc, `imem_rdata`} into the FIFO.
- Redirect has priority over everything:
  - FIFO cleared; `pc <= redirect_pc`; no request issued this cycle.
  - `drop_cnt <= outstanding - imem_rvalid`. A return arriving in the redirect cycle is also discarded.
  - A pop in the redirect cycle is still consumed by decode. Redirect is the upstream stage's responsibility to order against.
- `if_valid` = FIFO non-empty; `if_inst`/`if_pc` = FIFO head. These are combinational from registered FIFO state.
- `imem_rvalid` while `outstanding`=0 is a protocol error; it is flagged in simulation by an assertion.

## Timing
- Reset values: `pc`=RESET_PC, `outstanding`=0, `drop_cnt`=0, FIFO empty. Outputs: `if_valid`=0, `imem_req`=0, `imem_addr`=RESET_PC, `if_inst`/`if_pc`=0.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=RESET_PC.
- Latency, request acceptance to `if_valid`: memory latency + 1 cycle (FIFO write, read next cycle).
- Throughput:
  - Memory latency 1, DEPTH=2, no stall: one instruction per cycle sustained.
  - Memory latency L sustains one per cycle only if DEPTH ≥ L+1; otherwise DEPTH per L+1 cycles.
- FIFO full: issue blocks through the credit rule, so data is never lost. Empty: `if_valid`=0.
- `rst_n` low mid-operation: all state cleared at the next edge. Later memory returns are a system-level error; the memory is reset together with this block.
- Redirect to first new request: 1 cycle (request at `redirect_pc` in the cycle after `redirect`).

## Structure
- Shared package `cpu_pkg`: `PC_W`=32, `INST_W`=32, `PC_INC`=1, instruction field bit positions (rd/rs/rt/opcode). Decode uses the same constants.
- One sub-module, `fetch_fifo`: synchronous FIFO, parameter DEPTH/WIDTH, with push, pop, flush, count, and head output.
- The in-flight PC queue is a second `fetch_fifo` instance of depth DEPTH.

## Test plan
- Reset, memory latency 1, no stall:
  - `imem_addr` sequence 0,1,2,3.
  - `if_valid` rises 2 cycles after reset release.
  - `if_pc` 0,1,2,… one per cycle with matching `if_inst`.
- `id_stall` held 5 cycles mid-stream:
  - `imem_req` drops once FIFO + outstanding = 2.
  - `if_pc` holds; no instruction skipped or duplicated after release.
- `redirect` with `redirect_pc`=0x40 while 2 requests are outstanding (latency 3):
  - both returns discarded.
  - next `imem_addr`=0x40.
  - first `if_pc`=0x40.
- `redirect` in the same cycle as `imem_rvalid`: that word is never presented, and `drop_cnt` accounts for the remaining in-flight return.
- `imem_ready` randomly deasserted: `imem_addr` stable while `imem_req`=1 and not ready, and the PC sequence stays contiguous.
- `rst_n` pulsed low mid-stream: next cycle `if_valid`=0, `imem_addr`=RESET_PC, and fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU widths, PC increment and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    // Word addressing: consecutive instructions differ by one.
    localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int RD_MSB = 27;
    localparam int RD_LSB = 22;
    localparam int RS_MSB = 21;
    localparam int RS_LSB = 16;
    localparam int RT_MSB = 15;
    localparam int RT_LSB = 10;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO with flush, occupancy count and head output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    // Head reads as zero when empty so downstream never sees stale words.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch: PC, credit-limited imem requests, return FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc
);

    localparam int              CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CAP = (CW+1)'(DEPTH);

    logic [PC_W-1:0]   pc;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [PC_W-1:0]   inflight_pc;
    logic [CW:0]       credit_used;
    logic              pop;
    logic              accept;
    logic              keep_return;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign pop         = if_valid & ~id_stall;
    // Outstanding includes returns still to be dropped, so issue stays conservative.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - (CW+1)'(pop);
    assign imem_req    = rst_n & ~redirect & (credit_used < CAP);
    assign imem_addr   = pc;
    assign accept      = imem_req & imem_ready;
    assign keep_return = imem_rvalid & (drop_cnt == '0) & ~redirect;

    assign push_entry.pc   = inflight_pc;
    assign push_entry.inst = imem_rdata;

    // Every return pops the PC queue, kept or dropped, so its count tracks outstanding.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (accept),
        .din   (pc),
        .pop   (imem_rvalid),
        .head  (inflight_pc),
        .count (outstanding)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (keep_return),
        .din   (push_entry),
        .pop   (pop),
        .head  (head_entry),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            drop_cnt <= outstanding - CW'(imem_rvalid);
        end else begin
            if (accept) pc <= pc + PC_INC;
            if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    assign if_valid = (fifo_count != '0);
    assign if_inst  = head_entry.inst;
    assign if_pc    = head_entry.pc;

    a_no_spurious_return: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
    );

endmodule

`default_nettype wire
